cms_event_trace_unit: RTL and testbench
=======================================

# cms_event_trace_unit

Next-generation trace front end for the continuous monitoring system. It filters the committed-instruction stream by a runtime mode and attaches per-event counters accumulated since the previous packet to each kept instruction. Packets are buffered in an internal FIFO and emitted on an AXI4-Stream master toward the DMA FIFO, with interval-based and end-of-program tlast. The unit sits between the core's trace/event outputs and the AXI-Stream DMA path.

## Interface
- XLEN, 64: pc width.
- NUM_EVENTS, 4: number of event inputs.
- EVENT_WIDTH, 8: per-cycle increment width of each event.
- COUNTER_WIDTH, 16: accumulated counter width per event.
- FIFO_DEPTH, 16: packet buffer depth, power of two, ≥2.
- PKT_WIDTH (derived localparam): NUM_EVENTS*COUNTER_WIDTH + XLEN + 32 with CMS_EVENT_COUNTERS_EN; XLEN + 32 without it.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  committed instruction.
- pc  in  XLEN  its pc.
- pc_valid  in  1  instr/pc valid this cycle.
- events  in  NUM_EVENTS*EVENT_WIDTH  per-cycle event increments; event i occupies bits [i*EVENT_WIDTH +: EVENT_WIDTH].
- mode  in  2  filter mode.
- tlast_interval  in  32  packets per frame.
- M_AXIS_tvalid  out  1.
- M_AXIS_tready  in  1.
- M_AXIS_tdata  out  PKT_WIDTH  packet: {counters[NUM_EVENTS-1..0], pc, instr}.
- M_AXIS_tlast  out  1.
- dropped_count  out  32  packets lost to a full FIFO, saturating.
- program_finished  out  1  set after WFI.

## Operation
- Keep decision:
  - mode 0: all instructions kept.
  - mode 1: control flow only (opcode[6:0] = 1101111 JAL, 1100111 JALR, 1100011 BRANCH).
  - mode 2: JALR only.
  - mode 3: nothing kept.
  - WFI (32'h1050_0073) is always kept.
- Push condition: pc_valid & keep & !program_finished.
  - Accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the packet is dropped and dropped_count is incremented, saturating at 2^32-1.
- Event counters:
  - Each counter adds its event increment every cycle, saturating at 2^COUNTER_WIDTH-1.
  - An accepted packet carries counter + this cycle's increment (saturated).
  - The counter is 0 in the cycle after acceptance.
  - On a drop, counters are not cleared.
- tlast:
  - A frame counter counts accepted packets.
  - The packet making the count equal tlast_interval stores tlast=1 and resets the count to 0.
  - tlast_interval=0: interval tlast is never generated.
  - A WFI packet stores tlast=1 and resets the frame count.
  - If the WFI packet is dropped, the tlast bit of the most recently written FIFO entry is set instead. No effect if the FIFO is empty and that entry was already popped.
- program_finished: set on any pc_valid WFI, whether accepted or dropped. Cleared only by rst. It blocks all further pushes.
- FIFO: first-word fall-through. tvalid = not empty. tdata/tlast come from the head entry. Pop on tvalid & tready.

## Timing
- Accepted packet is visible at M_AXIS_* the cycle after the push edge (1-cycle latency into an empty FIFO).
- tdata and tlast are held stable while tvalid & !tready.
- Full FIFO with simultaneous pop and push: both occur and occupancy is unchanged.
- mode and tlast_interval are sampled each cycle; a change applies to the next instruction.
- Reset values (rst=1 during a clock edge): FIFO empty; M_AXIS_tvalid=0; M_AXIS_tlast=0; M_AXIS_tdata=0; counters 0; frame count 0; dropped_count 0; program_finished 0. Reset mid-stream discards all buffered packets.
- Mid-frame reset: no tlast is emitted for the partial frame.

## Configuration
- CMS_EVENT_COUNTERS_EN defined: counters are built and prepended to the packet (PKT_WIDTH as above).
- CMS_EVENT_COUNTERS_EN undefined: no counters; packet = {pc, instr}; the events input is present but ignored; all other behaviour is identical.

## Structure
- Shared package cms_pkg:
  - opcode constants (JAL, JALR, BRANCH);
  - CMS_WFI_INSTR;
  - filter-mode enum (ALL, CTRL_FLOW, INDIRECT, OFF);
  - a keep-decision function.
- Sub-module cms_trace_fifo:
  - FWFT synchronous FIFO of PKT_WIDTH+1 bits (tlast as MSB);
  - full/empty flags;
  - port to set the tlast bit of the tail entry.
- Filter, counters, frame counter and drop logic live in the top module.

## Test plan
- Mode 0, tlast_interval=3, tready=1, 7 valid instrs → 7 packets; tlast on packets 3 and 6; first tvalid one cycle after the first pc_valid.
- Mode 1, stream ADD, JAL, ADDI, JALR, BEQ → exactly 3 packets (JAL, JALR, BEQ). Mode 2 with the same stream → only JALR.
- Counters enabled, events[0]=2 every cycle, packets kept 5 cycles apart → counter field 10 per packet (first packet: cycles since reset). With COUNTER_WIDTH=4 and a long gap → saturates at 15.
- tready=0, FIFO_DEPTH=4, 6 kept instrs → 4 buffered, dropped_count=2. Release tready → the 4 original packets drain in order; the next accepted packet's counters include the dropped cycles.
- WFI while FIFO full → dropped_count increments, tail entry tlast=1, program_finished=1; later instrs produce no packets until rst.
- Assert rst with 3 packets buffered → next cycle tvalid=0, dropped_count=0, program_finished=0; the next instr yields a packet with a fresh frame count.

Source files
------------

// File: rtl/cms_pkg.sv
// Shared definitions for the CMS trace front end: opcodes, the WFI encoding,
// filter modes and the keep decision used by the trace filter.
package cms_pkg;

  localparam logic [6:0]  OPC_JAL       = 7'b1101111;
  localparam logic [6:0]  OPC_JALR      = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH    = 7'b1100011;
  localparam logic [31:0] CMS_WFI_INSTR = 32'h1050_0073;

  typedef enum logic [1:0] {
    MODE_ALL       = 2'd0,
    MODE_CTRL_FLOW = 2'd1,
    MODE_INDIRECT  = 2'd2,
    MODE_OFF       = 2'd3
  } filter_mode_e;

  // WFI is always kept so the end of program is visible in every mode.
  function automatic logic keep_instr(input logic [31:0] instr, input filter_mode_e mode);
    logic [6:0] opc;
    opc = instr[6:0];
    keep_instr = 1'b0;
    case (mode)
      MODE_ALL:       keep_instr = 1'b1;
      MODE_CTRL_FLOW: keep_instr = (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
      MODE_INDIRECT:  keep_instr = (opc == OPC_JALR);
      default:        keep_instr = 1'b0;
    endcase
    if (instr == CMS_WFI_INSTR) keep_instr = 1'b1;
  endfunction

endpackage

// File: rtl/cms_trace_fifo.sv
// First-word-fall-through packet buffer. The MSB of each entry is tlast; the
// tail entry's tlast can be set after the fact when a closing packet is lost.
module cms_trace_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             set_tail_last,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    tail_idx;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tail_idx  = wr_ptr_q[AW-1:0] - AW'(1);
  // Gate the head so the output bus reads zero while nothing is buffered.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and storage updates for push, pop and late tlast marking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (set_tail_last && !empty) mem_d[tail_idx][WIDTH-1] = 1'b1;
  end

  // Pointer registers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cms_event_trace_unit.sv
// Trace front end: filters committed instructions, attaches event counters
// accumulated since the previous packet, buffers packets and streams them
// out over AXI4-Stream with interval and end-of-program tlast.
// Optional feature macro: CMS_EVENT_COUNTERS_EN (builds the event counters
// and prepends them to each packet).
module cms_event_trace_unit
  import cms_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int NUM_EVENTS    = 4,
  parameter int EVENT_WIDTH   = 8,
  parameter int COUNTER_WIDTH = 16,
  parameter int FIFO_DEPTH    = 16,
`ifdef CMS_EVENT_COUNTERS_EN
  localparam int PKT_WIDTH    = NUM_EVENTS*COUNTER_WIDTH + XLEN + 32
`else
  localparam int PKT_WIDTH    = XLEN + 32
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       instr,
  input  logic [XLEN-1:0]                   pc,
  input  logic                              pc_valid,
  input  logic [NUM_EVENTS*EVENT_WIDTH-1:0] events,
  input  logic [1:0]                        mode,
  input  logic [31:0]                       tlast_interval,
  output logic                              M_AXIS_tvalid,
  input  logic                              M_AXIS_tready,
  output logic [PKT_WIDTH-1:0]              M_AXIS_tdata,
  output logic                              M_AXIS_tlast,
  output logic [31:0]                       dropped_count,
  output logic                              program_finished
);

  logic                 is_wfi, push_req, pop, accept, drop;
  logic                 fifo_full, fifo_empty, pkt_last;
  logic [PKT_WIDTH:0]   head_entry, push_entry;
  logic [PKT_WIDTH-1:0] pkt_body;
  logic [31:0]          frame_q, frame_d;
  logic [31:0]          dropped_q, dropped_d;
  logic                 finished_q, finished_d;

  assign is_wfi   = (instr == CMS_WFI_INSTR);
  assign push_req = pc_valid && keep_instr(instr, filter_mode_e'(mode)) && !finished_q;
  assign pop      = !fifo_empty && M_AXIS_tready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign accept   = push_req && (!fifo_full || pop);
  assign drop     = push_req && !accept;

`ifdef CMS_EVENT_COUNTERS_EN
  localparam int SUMW = ((COUNTER_WIDTH > EVENT_WIDTH) ? COUNTER_WIDTH : EVENT_WIDTH) + 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNTER_WIDTH-1:0]            cnt_q [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0]            cnt_d [NUM_EVENTS];
  logic [NUM_EVENTS*COUNTER_WIDTH-1:0] cnt_field;

  // Saturating accumulate; the packet carries this cycle's increment too.
  always_comb begin
    logic [SUMW-1:0] sum;
    cnt_field = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      sum = SUMW'(cnt_q[i]) + SUMW'(events[i*EVENT_WIDTH +: EVENT_WIDTH]);
      cnt_d[i] = (sum > SUMW'(CNT_MAX)) ? CNT_MAX : sum[COUNTER_WIDTH-1:0];
      cnt_field[i*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_d[i];
      if (accept) cnt_d[i] = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  assign pkt_body = {cnt_field, pc, instr};
`else
  logic unused_events;
  assign unused_events = ^events;
  assign pkt_body      = {pc, instr};
`endif

  // Frame counting and tlast decision for the packet being pushed.
  always_comb begin
    frame_d  = frame_q;
    pkt_last = 1'b0;
    if (accept) begin
      if (is_wfi || ((tlast_interval != 32'd0) && (frame_q + 32'd1 == tlast_interval))) begin
        pkt_last = 1'b1;
        frame_d  = '0;
      end else begin
        frame_d = frame_q + 32'd1;
      end
    end else if (drop && is_wfi) begin
      frame_d = '0;
    end
  end

  // Drop accounting and end-of-program latch.
  always_comb begin
    dropped_d  = dropped_q;
    finished_d = finished_q;
    if (drop && (dropped_q != 32'hFFFF_FFFF)) dropped_d = dropped_q + 32'd1;
    if (pc_valid && is_wfi) finished_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q    <= '0;
      dropped_q  <= '0;
      finished_q <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      dropped_q  <= dropped_d;
      finished_q <= finished_d;
    end
  end

  assign push_entry = {pkt_last, pkt_body};

  cms_trace_fifo #(
    .WIDTH (PKT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (accept),
    .push_data     (push_entry),
    .pop           (pop),
    .set_tail_last (drop && is_wfi),
    .head_data     (head_entry),
    .full          (fifo_full),
    .empty         (fifo_empty)
  );

  assign M_AXIS_tvalid    = !fifo_empty;
  assign M_AXIS_tdata     = head_entry[PKT_WIDTH-1:0];
  assign M_AXIS_tlast     = head_entry[PKT_WIDTH];
  assign dropped_count    = dropped_q;
  assign program_finished = finished_q;

endmodule

// File: tb/tb_cms_event_trace_unit.sv
// Directed bench for cms_event_trace_unit (FIFO_DEPTH=4, other defaults).
module tb_cms_event_trace_unit;

`ifdef CMS_EVENT_COUNTERS_EN
  localparam int PW = 4*16 + 64 + 32;
`else
  localparam int PW = 64 + 32;
`endif
  localparam logic [31:0] WFI = 32'h1050_0073;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic [63:0]   pc;
  logic          pc_valid;
  logic [31:0]   events;
  logic [1:0]    mode;
  logic [31:0]   tlast_interval;
  logic          tvalid, tready, tlast, pfin;
  logic [PW-1:0] tdata;
  logic [31:0]   dropped;

  int checks   = 0;
  int failures = 0;
  int npk;
  logic [31:0] b_stream [5];

  cms_event_trace_unit #(.FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr            (instr),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .events           (events),
    .mode             (mode),
    .tlast_interval   (tlast_interval),
    .M_AXIS_tvalid    (tvalid),
    .M_AXIS_tready    (tready),
    .M_AXIS_tdata     (tdata),
    .M_AXIS_tlast     (tlast),
    .dropped_count    (dropped),
    .program_finished (pfin)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_pkt(input logic [15:0] c0, input logic [63:0] p,
                                           input logic [31:0] ins);
`ifdef CMS_EVENT_COUNTERS_EN
    exp_pkt = {16'h0, 16'h0, 16'h0, c0, p, ins};
`else
    exp_pkt = {p, ins};
`endif
  endfunction

  function automatic logic [31:0] addi(input int i);
    addi = 32'h0000_0013 | (32'(i) << 20);
  endfunction

  task automatic do_reset;
    rst      = 1'b1;
    pc_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic run_filter(input logic [1:0] m, input logic [4:0] km, input int expn);
    do_reset;
    mode = m; tlast_interval = 0; tready = 1'b1;
    npk = 0;
    for (int k = 0; k < 5; k++) begin
      pc_valid = 1'b1; instr = b_stream[k]; pc = 64'h2000 + 64'(4*k);
      tick;
      check("filter_tvalid", tvalid, km[k]);
      if (tvalid) begin
        npk++;
        check("filter_instr", tdata[31:0], instr);
      end
    end
    pc_valid = 1'b0;
    tick;
    check("filter_count", npk, expn);
  endtask

  initial begin
    rst = 1'b1; pc_valid = 1'b0; instr = '0; pc = '0; events = '0;
    mode = 2'd0; tlast_interval = 32'd3; tready = 1'b1;
    b_stream[0] = 32'h00b5_0533;  // ADD
    b_stream[1] = 32'h0080_006f;  // JAL
    b_stream[2] = 32'h0010_0093;  // ADDI
    b_stream[3] = 32'h0000_8067;  // JALR
    b_stream[4] = 32'h0000_0463;  // BEQ
    tick; tick;
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_dropped", dropped, 0);
    check("rst_pfin", pfin, 0);
    rst = 1'b0;

    // Mode 0, interval 3, seven back-to-back instructions.
    check("a_idle_tvalid", tvalid, 0);
    for (int i = 0; i < 7; i++) begin
      pc_valid = 1'b1; instr = addi(i); pc = 64'h1000 + 64'(4*i);
      tick;
      check("a_tvalid", tvalid, 1);
      check("a_tdata", tdata, exp_pkt(16'd0, pc, instr));
      check("a_tlast", tlast, (i == 2 || i == 5));
    end
    pc_valid = 1'b0;
    tick;
    check("a_drained", tvalid, 0);

    // Filter modes over ADD, JAL, ADDI, JALR, BEQ.
    run_filter(2'd1, 5'b11010, 3);
    run_filter(2'd2, 5'b01000, 1);
    run_filter(2'd3, 5'b00000, 0);

    // Counter accumulation: events[0]=2, one packet every 5 cycles.
    events = 32'd2; mode = 2'd0; tlast_interval = 0; tready = 1'b1;
    do_reset;
    for (int j = 0; j < 3; j++) begin
      repeat (4) tick;
      pc_valid = 1'b1; instr = addi(j); pc = 64'h3000 + 64'(8*j);
      tick;
      pc_valid = 1'b0;
      check("c_pkt10", tdata, exp_pkt(16'd10, pc, instr));
    end
    events = 32'hff;
    repeat (300) tick;
    pc_valid = 1'b1; instr = addi(9); pc = 64'h3100;
    tick;
    check("c_sat", tdata, exp_pkt(16'hffff, pc, instr));
    instr = addi(10); pc = 64'h3104;
    tick;
    pc_valid = 1'b0;
    check("c_after_sat", tdata, exp_pkt(16'h00ff, pc, instr));

    // Backpressure: fill, drop two, then pop+push on a full FIFO and drain.
    events = 32'd1; tready = 1'b0; tlast_interval = 0;
    do_reset;
    for (int i = 0; i < 6; i++) begin
      pc_valid = 1'b1; instr = addi(i); pc = 64'h4000 + 64'(4*i);
      tick;
    end
    check("d_dropped", dropped, 2);
    check("d_tvalid_full", tvalid, 1);
    tready = 1'b1; pc_valid = 1'b1; instr = addi(6); pc = 64'h4018;
    check("d_head0", tdata, exp_pkt(16'd1, 64'h4000, addi(0)));
    tick;
    pc_valid = 1'b0;
    check("d_dropped_popush", dropped, 2);
    for (int k = 1; k < 4; k++) begin
      check("d_head", tdata, exp_pkt(16'd1, 64'h4000 + 64'(4*k), addi(k)));
      check("d_tlast", tlast, 0);
      tick;
    end
    check("d_head_after_drop", tdata, exp_pkt(16'd3, 64'h4018, addi(6)));
    tick;
    check("d_empty", tvalid, 0);

    // WFI while full: dropped, tail marked, program finished.
    events = 32'd0; tready = 1'b0;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1; instr = addi(i); pc = 64'h5000 + 64'(4*i);
      tick;
    end
    instr = WFI; pc = 64'h5010;
    tick;
    check("e_dropped", dropped, 1);
    check("e_pfin", pfin, 1);
    instr = addi(7); pc = 64'h5014;
    tick; tick;
    pc_valid = 1'b0;
    check("e_blocked_dropped", dropped, 1);
    tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("e_head_pc", tdata[95:32], 64'h5000 + 64'(4*k));
      check("e_tlast", tlast, (k == 3));
      tick;
    end
    check("e_empty", tvalid, 0);
    pc_valid = 1'b1; instr = addi(8); pc = 64'h5020;
    tick;
    pc_valid = 1'b0;
    check("e_no_push", tvalid, 0);

    // Mid-stream reset discards packets and the partial frame.
    tready = 1'b0; tlast_interval = 32'd3; mode = 2'd0;
    do_reset;
    check("f_pfin_cleared", pfin, 0);
    check("f_dropped_cleared", dropped, 0);
    for (int i = 0; i < 5; i++) begin
      pc_valid = 1'b1; instr = addi(i); pc = 64'h6000 + 64'(4*i);
      tick;
    end
    pc_valid = 1'b0;
    check("f_dropped_pre", dropped, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("f_tvalid", tvalid, 0);
    check("f_tdata", tdata, 0);
    check("f_tlast", tlast, 0);
    check("f_dropped", dropped, 0);
    tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_valid = 1'b1; instr = addi(k); pc = 64'h6100 + 64'(4*k);
      tick;
      check("f_frame_tlast", tlast, (k == 2));
    end
    pc_valid = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
